// File: rtl/noc_packet_injector.sv
// Network-interface injector: turns send requests into head/body/tail flits for a router port.
// Latency: request handshake N -> header valid N+2; payload handshake M -> body flit valid M+1.
// Backpressure: credit based toward the router (no ready); req_ready/pl_ready stall upstream.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   position_x                static tile x-coordinate (registered every cycle)
//   req_valid/ready, req_*    packet send request (destination, payload length)
//   pl_valid/ready, pl_data   payload flit stream from the local core
//   out_valid/head/tail/data  registered flit stream to the router injection port
//   credit_in, credit_err     buffer-slot return pulse; sticky credit overflow flag

package noc;
    typedef enum logic [4:0] {
        goLocal = 5'b00001,
        goEast  = 5'b00010,
        goWest  = 5'b00100,
        goNorth = 5'b01000,
        goSouth = 5'b10000
    } direction_t;
endpackage

module noc_packet_injector #(
    parameter int DATA_W  = 32,
    parameter int X_W     = 3,
    parameter int LEN_W   = 4,
    parameter int CREDITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [X_W-1:0]    position_x,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [X_W-1:0]    req_dest_x,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic [DATA_W-1:0] pl_data,
    output logic              out_valid,
    output logic              out_head,
    output logic              out_tail,
    output logic [DATA_W-1:0] out_data,
    input  logic              credit_in,
    output logic              credit_err
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0]    CRED_MAX = CW'(CREDITS);
    localparam logic [CW-1:0]    CRED_ONE = CW'(1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

    state_t           state, state_nxt;
    logic [X_W-1:0]   pos_q;
    logic [X_W-1:0]   dest_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] sent_q;
    logic [CW-1:0]    credits_q;

    logic             have_credit;
    logic             send;
    logic             last_body;
    logic             tail_nxt;
    noc::direction_t  route;
    logic [DATA_W-1:0] hdr;

    assign have_credit = (credits_q != '0);
    // Payload flit being accepted now is number sent_q+1 of the packet.
    assign last_body   = ((sent_q + LEN_ONE) == len_q);

    // First-hop direction: unsigned compare over the full coordinate width.
    always_comb begin
        route = noc::goLocal;
        if (dest_q > pos_q)
            route = noc::goEast;
        else if (dest_q < pos_q)
            route = noc::goWest;
    end

    always_comb begin
        hdr = '0;
        hdr[X_W-1:0]         = dest_q;
        hdr[2*X_W-1:X_W]     = pos_q;
        hdr[2*X_W+4:2*X_W]   = route;
        hdr[2*X_W+8:2*X_W+5] = 4'(len_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        pl_ready  = 1'b0;
        send      = 1'b0;
        tail_nxt  = 1'b0;
        case (state)
            IDLE: begin
                // State already reads IDLE during reset; keep the request blocked.
                req_ready = ~rst;
                if (req_valid && !rst)
                    state_nxt = HEAD;
            end
            HEAD: begin
                if (have_credit) begin
                    send      = 1'b1;
                    tail_nxt  = (len_q == '0);
                    state_nxt = (len_q == '0) ? IDLE : BODY;
                end
            end
            BODY: begin
                pl_ready = have_credit;
                if (pl_valid && have_credit) begin
                    send     = 1'b1;
                    tail_nxt = last_body;
                    if (last_body)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q      <= '0;
            dest_q     <= '0;
            len_q      <= '0;
            sent_q     <= '0;
            credits_q  <= CRED_MAX;
            credit_err <= 1'b0;
            out_valid  <= 1'b0;
            out_head   <= 1'b0;
            out_tail   <= 1'b0;
            out_data   <= '0;
        end else begin
            pos_q <= position_x;

            if (state == IDLE && req_valid) begin
                dest_q <= req_dest_x;
                len_q  <= req_len;
                sent_q <= '0;
            end else if (state == BODY && send) begin
                sent_q <= sent_q + LEN_ONE;
            end

            out_valid <= send;
            out_head  <= send && (state == HEAD);
            out_tail  <= tail_nxt;
            out_data  <= !send ? '0 : (state == HEAD) ? hdr : pl_data;

            // A send and a returned credit in the same cycle cancel out.
            case ({send, credit_in})
                2'b10: credits_q <= credits_q - CRED_ONE;
                2'b01: begin
                    if (credits_q == CRED_MAX)
                        credit_err <= 1'b1;
                    else
                        credits_q <= credits_q + CRED_ONE;
                end
                default: credits_q <= credits_q;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_packet_injector.sv
module tb_noc_packet_injector;

    localparam int DATA_W  = 32;
    localparam int X_W     = 3;
    localparam int LEN_W   = 4;
    localparam int CREDITS = 4;

    logic              clk;
    logic              rst;
    logic [X_W-1:0]    position_x;
    logic              req_valid;
    logic              req_ready;
    logic [X_W-1:0]    req_dest_x;
    logic [LEN_W-1:0]  req_len;
    logic              pl_valid;
    logic              pl_ready;
    logic [DATA_W-1:0] pl_data;
    logic              out_valid;
    logic              out_head;
    logic              out_tail;
    logic [DATA_W-1:0] out_data;
    logic              credit_in;
    logic              credit_err;

    noc_packet_injector #(
        .DATA_W(DATA_W), .X_W(X_W), .LEN_W(LEN_W), .CREDITS(CREDITS)
    ) dut (
        .clk(clk), .rst(rst), .position_x(position_x),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dest_x(req_dest_x), .req_len(req_len),
        .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
        .out_valid(out_valid), .out_head(out_head), .out_tail(out_tail),
        .out_data(out_data), .credit_in(credit_in), .credit_err(credit_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        head;
        logic        tail;
        logic [31:0] data;
        int          cyc;   // expected visible cycle, -1 when not timed
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int flits_seen = 0;
    int creds_sent = 0;
    int rst_adj = 0;
    int wasted = 0;
    int cr_d1 = 0;
    int cr_d2 = 0;
    int manual_req = 0;
    bit auto_cred = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Header built from the field layout with plain arithmetic.
    function automatic logic [31:0] hdr_model(int src, int dst, int len);
        int route;
        if (dst > src)      route = int'(noc::goEast);
        else if (dst < src) route = int'(noc::goWest);
        else                route = int'(noc::goLocal);
        return 32'(dst + (src << 3) + (route << 6) + ((len & 15) << 11));
    endfunction

    // Flits the router still holds (credits not yet returned).
    function automatic int pending();
        return flits_seen - rst_adj - creds_sent + wasted;
    endfunction

    task automatic run_packet(input int pos, input int dst, input int len, input bit timed);
        int n;
        exp_t e;
        @(posedge clk); #1;
        position_x = X_W'(pos);
        req_dest_x = X_W'(dst);
        req_len    = LEN_W'(len);
        req_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) begin
            chk("req_accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        e.head = 1'b1; e.tail = (len == 0); e.data = hdr_model(pos, dst, len);
        e.cyc  = timed ? cyc + 2 : -1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 1; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                pl_valid = 1'b0;
                @(posedge clk); #1;
            end
            pl_valid = 1'b1;
            pl_data  = $urandom;
            n = 0;
            @(negedge clk);
            while (!pl_ready && n < 200) begin @(negedge clk); n++; end
            if (!pl_ready) begin
                chk("payload_accept_timeout", 0, 1);
                pl_valid = 1'b0;
                return;
            end
            e.head = 1'b0; e.tail = (i == len); e.data = pl_data; e.cyc = cyc + 1;
            exp_q.push_back(e);
            @(posedge clk); #1;
            pl_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || pending() != 0) && n < 1000) begin
            @(negedge clk); n++;
        end
        chk("drain_done", (exp_q.size() == 0 && pending() == 0), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic monitor_cycle();
        exp_t e;
        if (rst) begin
            exp_q.delete();
            rst_adj = flits_seen - creds_sent + wasted;
        end else if (out_valid) begin
            flits_seen++;
            // Credits returned up to two cycles back are all the sender could have used.
            chk("credit_gate", (flits_seen - rst_adj - (cr_d2 - wasted)) <= CREDITS, 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_flit", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("flit_head", out_head, e.head);
                chk("flit_tail", out_tail, e.tail);
                chk("flit_data", out_data, e.data);
                if (e.cyc >= 0) chk("flit_latency", cyc, e.cyc);
            end
            if (out_tail) chk("idle_after_tail", req_ready, 1);
        end
        cr_d2 = cr_d1;
        cr_d1 = creds_sent;
    endtask

    initial begin
        int base;
        rst = 1'b1;
        position_x = '0; req_valid = 1'b0; req_dest_x = '0; req_len = '0;
        pl_valid = 1'b0; pl_data = '0; credit_in = 1'b0;

        fork
            forever begin @(posedge clk); cyc++; end
            forever begin
                @(posedge clk); #1;
                credit_in = 1'b0;
                if (!rst) begin
                    if (manual_req > 0) begin
                        credit_in = 1'b1; manual_req--; creds_sent++;
                    end else if (auto_cred && pending() > 0 && $urandom_range(0, 2) != 0) begin
                        credit_in = 1'b1; creds_sent++;
                    end
                end
            end
            forever begin @(negedge clk); monitor_cycle(); end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_pl_ready", pl_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_flags", {out_head, out_tail}, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_credit_err", credit_err, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("req_ready_after_rst", req_ready, 1);

        // Directed packets: east, west, local zero-length
        auto_cred = 1'b1;
        run_packet(2, 5, 2, 1'b1);
        wait_idle();
        run_packet(5, 1, 1, 1'b1);
        wait_idle();
        run_packet(3, 3, 0, 1'b1);
        wait_idle();
        chk("boundary_route_7_0", hdr_model(7, 0, 15) >> 6 & 31, int'(noc::goWest));

        // Random back-to-back traffic with random credit returns
        for (int p = 0; p < 20; p++)
            run_packet($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15), 1'b0);
        wait_idle();

        // Credit returned while the counter is full
        chk("credit_err_clear", credit_err, 0);
        wasted++;
        manual_req = 1;
        repeat (3) @(negedge clk);
        chk("credit_err_set", credit_err, 1);

        // Credit exhaustion: len 6 with no returns stops after 4 flits
        auto_cred = 1'b0;
        base = flits_seen;
        fork
            run_packet(6, 0, 6, 1'b1);
            begin
                repeat (30) @(negedge clk);
                chk("stall_flit_count", flits_seen - base, 4);
                chk("stall_pl_ready", pl_ready, 0);
                chk("stall_out_valid", out_valid, 0);
                manual_req = 1;
                repeat (6) @(negedge clk);
                chk("one_credit_one_flit", flits_seen - base, 5);
                chk("credit_err_sticky", credit_err, 1);
                auto_cred = 1'b1;
            end
        join
        wait_idle();

        // Reset in the middle of a packet
        auto_cred = 1'b0;
        @(posedge clk); #1;
        position_x = 3'd1; req_dest_x = 3'd6; req_len = 4'd3; req_valid = 1'b1;
        @(negedge clk);
        begin
            exp_t e;
            e.head = 1'b1; e.tail = 1'b0; e.data = hdr_model(1, 6, 3); e.cyc = cyc + 2;
            chk("abort_req_accept", req_ready, 1);
            exp_q.push_back(e);
            @(posedge clk); #1;
            req_valid = 1'b0;
            pl_valid = 1'b1; pl_data = 32'hA5A5_0001;
            @(negedge clk);
            while (!pl_ready && cyc < 90000) @(negedge clk);
            e.head = 1'b0; e.tail = 1'b0; e.data = pl_data; e.cyc = cyc + 1;
            exp_q.push_back(e);
            @(posedge clk); #1;
            pl_data = 32'hA5A5_0002;
        end
        // Body flit 1 is on the output now; reset lands while it is valid.
        #1;
        chk("abort_flit1_visible", out_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_bits", {out_head, out_tail, out_data}, 0);
        chk("abort_req_ready", req_ready, 0);
        chk("abort_pl_ready", pl_ready, 0);
        chk("abort_credit_err", credit_err, 0);
        pl_valid = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_req_ready_release", req_ready, 1);
        auto_cred = 1'b1;
        run_packet(4, 4, 2, 1'b1);
        wait_idle();
        chk("post_abort_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
